obc_da_sequencer: RTL and testbench

- Bit-serial controller for the offset-binary-coded distributed-arithmetic (OBC-DA) path of the 16-point DFT.
- Accepts one frame of NPTS parallel signed samples and walks their bit planes LSB→MSB, one plane per cycle.
- Each cycle it drives the half-size OBC ROM address and sign, then shift-accumulates the returned coefficient word.
- Delivers one signed DFT partial-sum result per frame through a valid/ready output port.

---
 rtl/obc_da_sequencer.sv | 135 +++++++++++++
 tb/tb_obc_da_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/obc_da_sequencer.sv
// OBC distributed-arithmetic bit-serial sequencer for the 16-point DFT.
// One frame in, one bit plane per cycle, one signed partial sum out.
module obc_da_sequencer #(
  parameter int DATA_W = 8,
  parameter int ROM_W  = 32,
  parameter int NPTS   = 16,
  localparam int BW    = $clog2(DATA_W),
  localparam int AW    = NPTS - 1,
  localparam int OW    = ROM_W + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NPTS*DATA_W-1:0] in_data,
  input  logic                   flush,
  output logic                   rom_en,
  output logic [AW-1:0]          rom_addr,
  input  logic [ROM_W-1:0]       rom_data,
  input  logic [ROM_W-1:0]       offset,
  output logic [BW-1:0]          bit_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [OW-1:0]           acc_q, acc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [NPTS*DATA_W-1:0]  samp_q, samp_d;
  logic [ROM_W-1:0]        off_q, off_d;
  logic [OW-1:0]           out_q, out_d;

  logic [NPTS-1:0]         slice;
  logic [AW-1:0]           addr_w;
  logic [OW-1:0]           rom_ext;
  logic [OW-1:0]           term;
  logic [OW-1:0]           acc_sh;
  logic [OW-1:0]           off_ext;
  logic                    last;

  // Bit-plane slice, OBC address folding and signed term
  always_comb begin
    slice = '0;
    for (int k = 0; k < NPTS; k++) begin
      slice[k] = samp_q[k*DATA_W + int'(bit_q)];
    end
    addr_w  = slice[NPTS-1:1] ^ {AW{slice[0]}};
    rom_ext = {{2{rom_data[ROM_W-1]}}, rom_data};
    term    = slice[0] ? (~rom_ext + OW'(1)) : rom_ext;
    acc_sh  = {acc_q[OW-1], acc_q[OW-1:1]};
    off_ext = {{2{off_q[ROM_W-1]}}, off_q};
    last    = (bit_q == BW'(DATA_W - 1));
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      off_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      off_q   <= off_d;
      out_q   <= out_d;
    end
  end

  // Next state; flush overrides load, progress and handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    off_d   = off_q;
    out_d   = out_q;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            samp_d  = in_data;
            off_d   = offset;
            acc_d   = '0;
            bit_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (last) begin
            acc_d   = acc_sh - term;
            out_d   = acc_sh - term + off_ext;
            bit_d   = '0;
            state_d = DONE;
          end else begin
            acc_d = acc_sh + term;
            bit_d = bit_q + BW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready  = (state_q == IDLE);
    rom_en    = (state_q == RUN);
    out_valid = (state_q == DONE);
    rom_addr  = rom_en ? addr_w : '0;
    bit_idx   = rom_en ? bit_q : '0;
    out_data  = out_q;
  end

endmodule

// File: tb/tb_obc_da_sequencer.sv
// Self-checking bench for obc_da_sequencer.
// Directed frames plus random frames against a plane-by-plane model.
module tb_obc_da_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         flush = 1'b0;
  logic         rom_en;
  logic [14:0]  rom_addr;
  logic [31:0]  rom_data;
  logic [31:0]  offset = '0;
  logic [2:0]   bit_idx;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [33:0]  out_data;

  int errors = 0;
  int checks = 0;
  int rom_mode = 0;

  obc_da_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush),
    .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .offset(offset),
    .bit_idx(bit_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(int m, logic [14:0] a);
    logic [31:0] r;
    if (m == 0) r = 32'd256;
    else if (m == 1) r = {17'b0, a};
    else r = {17'b0, a} * 32'h9E3779B1 + 32'h01234567;
    return r;
  endfunction

  always_comb rom_data = rom_fn(rom_mode, rom_addr);

  // returns {sign, address} for bit plane j
  function automatic logic [15:0] plane(logic [127:0] d, int j);
    logic s;
    logic [14:0] a;
    s = d[j];
    for (int k = 1; k < 16; k++) a[k-1] = d[k*8+j] ^ s;
    return {s, a};
  endfunction

  function automatic logic [33:0] model(logic [127:0] d,
                                        logic [31:0] off, int m);
    longint acc, t;
    logic [15:0] p;
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      p = plane(d, j);
      t = longint'($signed(rom_fn(m, p[14:0])));
      if (p[15]) t = -t;
      acc = (acc >>> 1) + ((j == 7) ? -t : t);
    end
    acc = acc + longint'($signed(off));
    return acc[33:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(logic [127:0] d, logic [31:0] off, int m,
                           logic [33:0] exp, int hold,
                           bit pre, logic [127:0] nd);
    int n;
    logic [15:0] p;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    rom_mode = m;
    in_valid = 1'b1;
    in_data  = d;
    offset   = off;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      p = plane(d, j);
      chk("rom_en_run", 64'(rom_en), 64'd1);
      chk("bit_idx", 64'(bit_idx), 64'(j));
      chk("rom_addr", 64'(rom_addr), 64'(p[14:0]));
      chk("in_ready_run", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    chk("out_valid_rise", 64'(out_valid), 64'd1);
    chk("out_data", 64'(out_data), 64'(exp));
    chk("rom_en_done", 64'(rom_en), 64'd0);
    if (pre) begin
      in_valid = 1'b1;
      in_data  = nd;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(exp));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_fall", 64'(out_valid), 64'd0);
    chk("out_data_keep", 64'(out_data), 64'(exp));
    chk("in_ready_after", 64'(in_ready), 64'd1);
    if (pre) chk("no_early_load", 64'(rom_en), 64'd0);
  endtask

  initial begin
    logic [127:0] d, d2;
    logic [31:0] off;
    int seen;

    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_rom_en", 64'(rom_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bit_idx", 64'(bit_idx), 64'd0);

    // directed frames
    run_frame('0, 32'd0, 0, -34'sd2, 0, 1'b0, '0);
    run_frame(128'hFF, 32'd0, 0, 34'd2, 0, 1'b0, '0);
    run_frame(128'hFF, 32'd100, 0, 34'd102, 0, 1'b0, '0);
    run_frame(128'h0100, 32'd0, 1, 34'd0, 0, 1'b0, '0);

    // backpressure with a second frame waiting
    d2 = 128'h0000_0000_0000_0000_0000_0000_0000_FF00;
    run_frame(128'hFF, 32'd5, 0, 34'd7, 5, 1'b1, d2);
    run_frame(d2, 32'd5, 1, model(d2, 32'd5, 1), 0, 1'b0, '0);

    // async reset mid-run
    rom_mode = 2;
    d = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    in_data  = d;
    offset   = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_bit", 64'(bit_idx), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rom_en", 64'(rom_en), 64'd0);
    chk("arst_bit_idx", 64'(bit_idx), 64'd0);
    chk("arst_rom_addr", 64'(rom_addr), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || rom_en) seen++;
    end
    chk("no_out_after_rst", 64'(seen), 64'd0);
    run_frame(d, 32'd9, 2, model(d, 32'd9, 2), 1, 1'b0, '0);

    // flush mid-run
    d = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_flush_bit", 64'(bit_idx), 64'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_rom_en", 64'(rom_en), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // flush together with in_valid in IDLE
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_noload", 64'(rom_en), 64'd0);
    chk("flush_idle", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || rom_en) seen++;
    end
    chk("no_out_after_flush", 64'(seen), 64'd0);
    run_frame(d, 32'd0, 2, model(d, 32'd0, 2), 0, 1'b0, '0);

    // random frames
    for (int r = 0; r < 8; r++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      off = $urandom;
      run_frame(d, off, 2, model(d, off, 2),
                $urandom_range(0, 3), 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
